// File: rtl/mmcm_drp_rmw_pkg.sv
// Shared definitions for the MMCM DRP read-modify-write sequencer:
// state encoding and the stale-lock guard length.
package mmcm_drp_rmw_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_MODIFY,
      ST_WR_ISSUE,
      ST_WR_WAIT,
      ST_LOCK_WAIT
   } state_e;

   // LOCKED is ignored for this many cycles after MMCM reset release.
   localparam int unsigned LOCK_GUARD = 4;

endpackage

// File: rtl/mmcm_drp_rmw.sv
// MMCM DRP sequencer: one read or masked read-modify-write per request, holds
// the MMCM in reset across a reconfiguration and waits for LOCKED after the last write.
module mmcm_drp_rmw #(
   parameter int pTIMEOUT_W      = 10,
   parameter int pLOCK_TIMEOUT_W = 16
) (
   input  logic        clk_usb,
   input  logic        reset_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_last,
   input  logic [6:0]  req_addr,
   input  logic [15:0] req_din,
   input  logic [15:0] req_mask,
   output logic        rsp_valid,
   output logic [15:0] rsp_dout,
   output logic        rsp_timeout,
   output logic        busy,
   output logic [6:0]  drp_addr,
   output logic        drp_den,
   output logic        drp_dwe,
   output logic [15:0] drp_din,
   input  logic [15:0] drp_dout,
   input  logic        drp_drdy,
   output logic        mmcm_rst,
   input  logic        mmcm_locked
);
   import mmcm_drp_rmw_pkg::*;

   localparam int CW = (pLOCK_TIMEOUT_W > pTIMEOUT_W) ? pLOCK_TIMEOUT_W : pTIMEOUT_W;
   localparam logic [CW-1:0] RD_MAX   = CW'((64'd1 << pTIMEOUT_W) - 64'd1);
   localparam logic [CW-1:0] LOCK_MAX = CW'((64'd1 << pLOCK_TIMEOUT_W) - 64'd1);
   localparam logic [CW-1:0] GUARD    = CW'(LOCK_GUARD);

   state_e         state_q, state_d;
   logic [6:0]     addr_q, addr_d;
   logic [15:0]    din_q, din_d;
   logic [15:0]    mask_q, mask_d;
   logic           we_q, we_d;
   logic           last_q, last_d;
   logic [15:0]    drp_din_q, drp_din_d;
   logic [15:0]    rsp_dout_q, rsp_dout_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_timeout_q, rsp_timeout_d;
   logic           mmcm_rst_q, mmcm_rst_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk_usb or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         din_q         <= '0;
         mask_q        <= '0;
         we_q          <= 1'b0;
         last_q        <= 1'b0;
         drp_din_q     <= '0;
         rsp_dout_q    <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         mmcm_rst_q    <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         din_q         <= din_d;
         mask_q        <= mask_d;
         we_q          <= we_d;
         last_q        <= last_d;
         drp_din_q     <= drp_din_d;
         rsp_dout_q    <= rsp_dout_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
         mmcm_rst_q    <= mmcm_rst_d;
         cnt_q         <= cnt_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path infers a latch.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      din_d         = din_q;
      mask_d        = mask_q;
      we_d          = we_q;
      last_d        = last_q;
      drp_din_d     = drp_din_q;
      rsp_dout_d    = rsp_dout_q;
      rsp_valid_d   = 1'b0;
      rsp_timeout_d = rsp_timeout_q;
      mmcm_rst_d    = mmcm_rst_q;
      cnt_d         = cnt_q + CW'(1);

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d        = req_addr;
               din_d         = req_din;
               mask_d        = req_mask;
               we_d          = req_we;
               last_d        = req_last;
               rsp_timeout_d = 1'b0;
               if (req_we) mmcm_rst_d = 1'b1;
               if (req_we && (req_mask == 16'h0000)) begin
                  drp_din_d = req_din;
                  state_d   = ST_WR_ISSUE;
               end else begin
                  state_d   = ST_RD_ISSUE;
               end
            end
         end
         ST_RD_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (drp_drdy) begin
               if (we_q) begin
                  // drp_din is idle during the read phase, so it parks the old value.
                  drp_din_d = drp_dout;
                  state_d   = ST_MODIFY;
               end else begin
                  rsp_dout_d  = drp_dout;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end else if (cnt_q == RD_MAX) begin
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               mmcm_rst_d    = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         ST_MODIFY: begin
            drp_din_d = (drp_din_q & mask_q) | (din_q & ~mask_q);
            state_d   = ST_WR_ISSUE;
         end
         ST_WR_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            if (drp_drdy) begin
               rsp_dout_d = drp_din_q;
               if (last_q) begin
                  cnt_d      = '0;
                  mmcm_rst_d = 1'b0;
                  state_d    = ST_LOCK_WAIT;
               end else begin
                  rsp_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end else if (cnt_q == RD_MAX) begin
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               mmcm_rst_d    = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         ST_LOCK_WAIT: begin
            if (mmcm_locked && (cnt_q >= GUARD)) begin
               rsp_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (cnt_q == LOCK_MAX) begin
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign busy        = ~req_ready;
   assign drp_den     = (state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE);
   assign drp_dwe     = (state_q == ST_WR_ISSUE);
   assign drp_addr    = addr_q;
   assign drp_din     = drp_din_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_dout    = rsp_dout_q;
   assign rsp_timeout = rsp_timeout_q;
   assign mmcm_rst    = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_drp_rmw.sv
// Self-checking bench for mmcm_drp_rmw: behavioural MMCM DRP/LOCKED model,
// directed vector table, multi-cycle corner sequences and a randomized phase.
module tb_mmcm_drp_rmw;

   logic        clk_usb = 1'b0;
   logic        reset_i = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic        req_last = 1'b0;
   logic [6:0]  req_addr = '0;
   logic [15:0] req_din = '0;
   logic [15:0] req_mask = '0;
   logic        rsp_valid;
   logic [15:0] rsp_dout;
   logic        rsp_timeout;
   logic        busy;
   logic [6:0]  drp_addr;
   logic        drp_den;
   logic        drp_dwe;
   logic [15:0] drp_din;
   logic [15:0] drp_dout;
   logic        drp_drdy;
   logic        mmcm_rst;
   logic        mmcm_locked = 1'b0;

   mmcm_drp_rmw dut (
      .clk_usb(clk_usb), .reset_i(reset_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_last(req_last),
      .req_addr(req_addr), .req_din(req_din), .req_mask(req_mask),
      .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .rsp_timeout(rsp_timeout), .busy(busy),
      .drp_addr(drp_addr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_din(drp_din),
      .drp_dout(drp_dout), .drp_drdy(drp_drdy),
      .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
   );

   always #5 clk_usb = ~clk_usb;

   int n_cmp = 0;
   int n_err = 0;

   // MMCM DRP model knobs and monitors
   int  mdl_lat    = 2;
   bit  drdy_en    = 1'b1;
   int  lock_mode  = 0;   // 0: lock lock_delay cycles after release, 1: always high, 2: never
   int  lock_delay = 9;
   int  rd_cnt     = 0;
   int  wr_cnt     = 0;
   int  proto_err  = 0;
   logic        rst_at_wr = 1'b0;
   logic [15:0] mdl_regs [128];
   logic [15:0] ref_regs [128];
   logic [15:0] prdata;
   logic        pend;
   int          pcnt;
   logic        den_prev;
   int          rel_cnt = 0;

   function automatic logic [15:0] init_val(input int i);
      logic [15:0] v;
      v = 16'(i * 40503) ^ 16'h5A5A;
      if (i == 8) v = 16'h1041;
      if (i == 9) v = 16'hA5A5;
      return v;
   endfunction

   always @(posedge clk_usb or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < 128; i++) mdl_regs[i] <= init_val(i);
         drp_drdy <= 1'b0;
         drp_dout <= '0;
         prdata   <= '0;
         pend     <= 1'b0;
         pcnt     <= 0;
         den_prev <= 1'b0;
      end else begin
         drp_drdy <= 1'b0;
         den_prev <= drp_den;
         if ((drp_den && den_prev) || (drp_dwe && !drp_den)) proto_err <= proto_err + 1;
         if (drp_den) begin
            if (drp_dwe) begin
               mdl_regs[drp_addr] <= drp_din;
               wr_cnt    <= wr_cnt + 1;
               rst_at_wr <= mmcm_rst;
            end else begin
               rd_cnt <= rd_cnt + 1;
            end
            prdata <= mdl_regs[drp_addr];
            if (drdy_en) begin
               if (mdl_lat <= 1) begin
                  drp_drdy <= 1'b1;
                  drp_dout <= mdl_regs[drp_addr];
               end else begin
                  pend <= 1'b1;
                  pcnt <= mdl_lat - 1;
               end
            end
         end else if (pend) begin
            if (pcnt == 1) begin
               drp_drdy <= 1'b1;
               drp_dout <= prdata;
               pend     <= 1'b0;
            end else begin
               pcnt <= pcnt - 1;
            end
         end
      end
   end

   always @(posedge clk_usb) begin
      if (mmcm_rst) rel_cnt <= 0;
      else if (rel_cnt < 1000000) rel_cnt <= rel_cnt + 1;
      case (lock_mode)
         1:       mmcm_locked <= 1'b1;
         2:       mmcm_locked <= 1'b0;
         default: mmcm_locked <= !mmcm_rst && (rel_cnt >= lock_delay);
      endcase
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_cmp++;
      if (got < lo || got > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   // Called one negedge after the accepting edge; cyc counts negedges since it.
   task automatic wait_rsp(input int budget, output int cyc, output bit ok);
      cyc = 1;
      ok  = 1'b0;
      while (cyc <= budget) begin
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_usb);
         cyc++;
      end
   endtask

   task automatic issue(input bit we, input bit last, input logic [6:0] a,
                        input logic [15:0] d, input logic [15:0] m);
      int t;
      t = 0;
      while (!req_ready && t < 100) begin
         @(negedge clk_usb);
         t++;
      end
      req_valid = 1'b1; req_we = we; req_last = last;
      req_addr = a; req_din = d; req_mask = m;
      @(negedge clk_usb);
      req_valid = 1'b0;
   endtask

   task automatic do_req(input bit we, input bit last, input logic [6:0] a,
                         input logic [15:0] d, input logic [15:0] m,
                         input int budget, output int cyc, output bit ok);
      issue(we, last, a, d, m);
      wait_rsp(budget, cyc, ok);
   endtask

   typedef struct {
      bit          we;
      bit          last;
      logic [6:0]  addr;
      logic [15:0] din;
      logic [15:0] mask;
      int          lat;
      logic [15:0] exp_dout;
      int          exp_rd;
      int          exp_wr;
      bit          exp_rst;
      int          exp_cyc;   // -1: not checked
   } vec_t;

   vec_t vecs [7];

   initial begin
      int cyc, rd0, wr0, exp_rd, exp_wr;
      bit ok, we, last, ref_rst;
      logic [6:0]  a;
      logic [15:0] d, m, old, exp_dout;

      vecs[0] = '{1'b0, 1'b0, 7'h08, 16'h0000, 16'hFFFF, 2, 16'h1041, 1, 0, 1'b0, 4};
      vecs[1] = '{1'b1, 1'b0, 7'h09, 16'h00C3, 16'hFC00, 2, 16'hA4C3, 1, 1, 1'b1, 8};
      vecs[2] = '{1'b0, 1'b0, 7'h09, 16'h0000, 16'h0000, 1, 16'hA4C3, 1, 0, 1'b1, 3};
      vecs[3] = '{1'b1, 1'b0, 7'h08, 16'hFFFF, 16'h00FF, 2, 16'hFF41, 1, 1, 1'b1, 8};
      vecs[4] = '{1'b1, 1'b1, 7'h0A, 16'h1234, 16'h0000, 3, 16'h1234, 0, 1, 1'b0, -1};
      vecs[5] = '{1'b0, 1'b0, 7'h0A, 16'h0000, 16'h0000, 1, 16'h1234, 1, 0, 1'b0, 3};
      vecs[6] = '{1'b0, 1'b0, 7'h08, 16'h0000, 16'hFFFF, 3, 16'hFF41, 1, 0, 1'b0, 5};

      // Reset state
      repeat (3) @(negedge clk_usb);
      check("rst_req_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_dout", rsp_dout, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_mmcm_rst", mmcm_rst, 0);
      check("rst_drp_den", drp_den, 0);
      reset_i = 1'b0;
      @(negedge clk_usb);
      check("post_rst_req_ready", req_ready, 1);

      // Directed vectors
      for (int i = 0; i < 7; i++) begin
         mdl_lat = vecs[i].lat;
         rd0 = rd_cnt;
         wr0 = wr_cnt;
         do_req(vecs[i].we, vecs[i].last, vecs[i].addr, vecs[i].din, vecs[i].mask, 500, cyc, ok);
         check($sformatf("vec%0d_done", i), ok, 1);
         check($sformatf("vec%0d_dout", i), rsp_dout, vecs[i].exp_dout);
         check($sformatf("vec%0d_timeout", i), rsp_timeout, 0);
         check($sformatf("vec%0d_rd_strobes", i), rd_cnt - rd0, vecs[i].exp_rd);
         check($sformatf("vec%0d_wr_strobes", i), wr_cnt - wr0, vecs[i].exp_wr);
         check($sformatf("vec%0d_mmcm_rst", i), mmcm_rst, vecs[i].exp_rst);
         if (vecs[i].exp_wr != 0) check($sformatf("vec%0d_rst_at_wr", i), rst_at_wr, 1);
         if (vecs[i].exp_cyc >= 0) check($sformatf("vec%0d_latency", i), cyc, vecs[i].exp_cyc);
         @(negedge clk_usb);
         check($sformatf("vec%0d_pulse", i), rsp_valid, 0);
      end

      // Stale-lock guard: LOCKED already high when reset is released
      lock_mode = 1;
      mdl_lat   = 1;
      do_req(1'b1, 1'b1, 7'h20, 16'h0F0F, 16'h0000, 500, cyc, ok);
      check("stale_done", ok, 1);
      check_range("stale_guard_latency", cyc, 7, 9);
      check("stale_mmcm_rst", mmcm_rst, 0);
      check("stale_timeout", rsp_timeout, 0);
      lock_mode = 0;

      // Read with no drdy: timeout, then cleared by the next accepted request
      drdy_en = 1'b0;
      do_req(1'b0, 1'b0, 7'h08, 16'h0, 16'hFFFF, 3000, cyc, ok);
      check("rdtmo_done", ok, 1);
      check("rdtmo_flag", rsp_timeout, 1);
      check_range("rdtmo_latency", cyc, 1023, 1028);
      check("rdtmo_mmcm_rst", mmcm_rst, 0);
      drdy_en = 1'b1;
      issue(1'b0, 1'b0, 7'h08, 16'h0, 16'hFFFF);
      check("rdtmo_clear_on_accept", rsp_timeout, 0);
      wait_rsp(500, cyc, ok);
      check("rdtmo_next_done", ok, 1);
      check("rdtmo_next_dout", rsp_dout, 16'hFF41);
      check("rdtmo_next_flag", rsp_timeout, 0);

      // Asynchronous reset while stuck in WR_WAIT with MMCM held in reset
      drdy_en = 1'b0;
      issue(1'b1, 1'b0, 7'h05, 16'hBEEF, 16'h0000);
      repeat (5) @(negedge clk_usb);
      check("abort_pre_mmcm_rst", mmcm_rst, 1);
      check("abort_pre_busy", busy, 1);
      reset_i = 1'b1;
      #1;
      check("abort_mmcm_rst", mmcm_rst, 0);
      check("abort_rsp_dout", rsp_dout, 0);
      check("abort_drp_den", drp_den, 0);
      check("abort_drp_dwe", drp_dwe, 0);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_busy", busy, 0);
      @(negedge clk_usb);
      reset_i = 1'b0;
      drdy_en = 1'b1;
      @(negedge clk_usb);
      check("abort_req_ready", req_ready, 1);

      // Randomized requests against the reference model (regs re-initialised by reset)
      for (int i = 0; i < 128; i++) ref_regs[i] = init_val(i);
      ref_rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         we   = 1'($urandom_range(0, 1));
         a    = 7'($urandom_range(0, 15));
         d    = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       m = 16'h0000;
            1:       m = 16'hFFFF;
            default: m = 16'($urandom);
         endcase
         last       = we && ($urandom_range(0, 5) == 0);
         mdl_lat    = $urandom_range(1, 4);
         lock_delay = $urandom_range(0, 12);
         old = ref_regs[a];
         if (we) begin
            exp_dout    = (m == 16'h0000) ? d : ((old & m) | (d & ~m));
            ref_regs[a] = exp_dout;
            exp_rd      = (m == 16'h0000) ? 0 : 1;
            exp_wr      = 1;
            ref_rst     = !last;
         end else begin
            exp_dout = old;
            exp_rd   = 1;
            exp_wr   = 0;
         end
         rd0 = rd_cnt;
         wr0 = wr_cnt;
         do_req(we, last, a, d, m, 2000, cyc, ok);
         check($sformatf("rnd%0d_done", n), ok, 1);
         check($sformatf("rnd%0d_dout", n), rsp_dout, exp_dout);
         check($sformatf("rnd%0d_timeout", n), rsp_timeout, 0);
         check($sformatf("rnd%0d_rd_strobes", n), rd_cnt - rd0, exp_rd);
         check($sformatf("rnd%0d_wr_strobes", n), wr_cnt - wr0, exp_wr);
         check($sformatf("rnd%0d_mmcm_rst", n), mmcm_rst, ref_rst);
         @(negedge clk_usb);
      end

      // Last write with LOCKED never asserting: lock-wait timeout
      lock_mode = 2;
      mdl_lat   = 1;
      do_req(1'b1, 1'b1, 7'h30, 16'h5555, 16'h0000, 70000, cyc, ok);
      check("locktmo_done", ok, 1);
      check("locktmo_flag", rsp_timeout, 1);
      check("locktmo_mmcm_rst", mmcm_rst, 0);
      check_range("locktmo_latency", cyc, 65535, 65545);

      check("protocol_violations", proto_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mmcm_drp_rmw.md
Name: mmcm_drp_rmw

Overview:
- Sits between the USB-register DRP front end and the MMCM DRP port.
- Accepts one request at a time: read, or masked read-modify-write.
- Sequences DRP strobes per the MMCM DRP protocol and holds the MMCM in reset across a multi-write reconfiguration.
- After the last write, waits for LOCKED and reports completion or timeout status back to the register block.

Parameters:
pTIMEOUT_W, 10, width of the timeout counter; timeout fires after 2**pTIMEOUT_W-1 cycles.
pLOCK_TIMEOUT_W, 16, width of the lock-wait counter.

Ports:
clk_usb  in  1  sole clock.
reset_i  in  1  asynchronous, active-high reset.
req_valid  in  1  request strobe; sampled only when req_ready=1.
req_ready  out  1  high in IDLE only.
req_we  in  1  1=masked write, 0=read.
req_last  in  1  on a write: final write of the reconfiguration; triggers reset release and lock wait.
req_addr  in  7  DRP address.
req_din  in  16  write data.
req_mask  in  16  bit=1 keeps old register bit; bit=0 takes req_din bit.
rsp_valid  out  1  one-cycle pulse at request completion.
rsp_dout  out  16  read data (read), or value written (write); held until next rsp_valid.
rsp_timeout  out  1  sticky error flag; cleared by next accepted request.
busy  out  1  ~req_ready.
drp_addr  out  7  to MMCM.
drp_den  out  1  to MMCM.
drp_dwe  out  1  to MMCM.
drp_din  out  16  to MMCM.
drp_dout  in  16  from MMCM.
drp_drdy  in  1  from MMCM.
mmcm_rst  out  1  MMCM reset.
mmcm_locked  in  1  MMCM LOCKED (already synchronous to clk_usb).

Behaviour:
- Reset: all outputs 0; state IDLE; req_ready=1. rsp_dout=0, rsp_timeout=0, mmcm_rst=0.
- Reset mid-operation: aborts; mmcm_rst returns to 0; any DRP transaction in flight is abandoned.
- IDLE: on req_valid:
  - Latch addr/din/mask/we/last.
  - Clear rsp_timeout.
  - On a write, set mmcm_rst=1 in the same edge.
  - Go to RD_ISSUE; if we=1 and mask==16'h0000, go to WR_ISSUE instead (read skipped).
- RD_ISSUE: drp_den=1, drp_dwe=0 for exactly one cycle, drp_addr=latched address. Go to RD_WAIT.
- RD_WAIT: count cycles.
  - On drp_drdy: capture drp_dout.
    - Read request: rsp_dout=capture, rsp_valid pulse, go to IDLE.
    - Write request: go to MODIFY.
  - On counter saturation: rsp_timeout=1, rsp_valid pulse, mmcm_rst=0, go to IDLE.
- MODIFY: one cycle; drp_din <= (old & mask) | (din & ~mask). Go to WR_ISSUE.
- WR_ISSUE: drp_den=1, drp_dwe=1 for exactly one cycle. When the read was skipped, drp_din=din. Go to WR_WAIT.
- WR_WAIT: on drp_drdy, rsp_dout=drp_din.
  - last=1: go to LOCK_WAIT.
  - Else: rsp_valid pulse, go to IDLE with mmcm_rst still 1.
  - Timeout is handled as in RD_WAIT.
- LOCK_WAIT:
  - First cycle: mmcm_rst=0.
  - Count until mmcm_locked=1, then rsp_valid pulse and go to IDLE.
  - On lock-counter saturation: rsp_timeout=1, rsp_valid pulse, go to IDLE.
  - mmcm_locked is ignored for the first 4 cycles after reset release (stale-lock guard).
- drp_den and drp_dwe are never high outside the ISSUE states. drp_addr and drp_din are stable from ISSUE until drdy.
- Stray drp_drdy outside a WAIT state: ignored.
- A read issued while mmcm_rst=1 (mid-sequence) is legal and does not change mmcm_rst.
- Counters reset to 0 on entry to each WAIT state.
- Latency, read, drdy one cycle after den: rsp_valid 3 cycles after the accepting edge.

Decomposition:
- Shared package/includes holds:
  - State encoding constants: IDLE, RD_ISSUE, RD_WAIT, MODIFY, WR_ISSUE, WR_WAIT, LOCK_WAIT.
  - The stale-lock guard count, 4.
- No sub-module needed. The timeout counter may be a small generic saturating counter (sat_counter) reused for both waits.

Test Plan:
- Read addr 7'h08, MMCM model returns 16'h1041 with drp_drdy 2 cycles after den -> one den pulse with dwe=0; rsp_valid with rsp_dout=16'h1041; mmcm_rst stays 0.
- Write addr 7'h09, din 16'h00C3, mask 16'hFC00, old 16'hA5A5 -> read, then write drp_din=16'hA4C3; rsp_valid; mmcm_rst=1 held since accept.
- Write mask 16'h0000, din 16'h1234, last=1 -> no read strobe; single write of 16'h1234; mmcm_rst falls; locked raised 10 cycles later -> rsp_valid, rsp_timeout=0.
- Model never asserts drdy on a read -> rsp_timeout=1 and rsp_valid after 1023 cycles; next accepted request clears rsp_timeout.
- Write with last=1 and locked held low -> timeout after 65535 cycles; mmcm_rst=0; rsp_timeout=1.
- Assert reset_i during WR_WAIT with mmcm_rst=1 -> all outputs 0 immediately (async); req_ready=1 after release.
